// File: rtl/led_strip_pkg.sv
// Shared definitions for the LED-strip controller: op-code values, the mode
// encoding, the 24-bit colour type and the solid-colour palette.
package led_strip_pkg;

  localparam logic [3:0] OP_NOP         = 4'd0;
  localparam logic [3:0] OP_POWER_ON    = 4'd1;
  localparam logic [3:0] OP_MODE_NEXT   = 4'd2;
  localparam logic [3:0] OP_MODE_PREV   = 4'd3;
  localparam logic [3:0] OP_COLOR_NEXT  = 4'd4;
  localparam logic [3:0] OP_COLOR_UNDO  = 4'd5;
  localparam logic [3:0] OP_BRIGHT_UP   = 4'd6;
  localparam logic [3:0] OP_BRIGHT_DOWN = 4'd7;
  // op-codes 8..15 are SET_COLOR with the palette index in op[2:0]

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_RAINBOW = 2'd2,
    MODE_CHASE   = 2'd3
  } mode_e;

  typedef logic [23:0] rgb_t;  // {R,G,B}

  localparam rgb_t SOLID_PALETTE [8] = '{
    24'hFF0000,  // red
    24'h00FF00,  // green
    24'h0000FF,  // blue
    24'hFFFF00,  // yellow
    24'hFF6400,  // orange
    24'hFF00FF,  // pink
    24'h6400FF,  // purple
    24'hFFFFFF   // white
  };

endpackage

// File: rtl/led_hue_wheel.sv
// Combinational hue wheel: 8-bit hue -> fully saturated RGB.
// Three sectors of 85 steps (R->G, G->B, B->R), each channel ramping by 3/step.
// Ports: hue_i (8b hue), rgb_o (24b {R,G,B}).
module led_hue_wheel
  import led_strip_pkg::*;
(
  input  logic [7:0] hue_i,
  output rgb_t       rgb_o
);

  logic [7:0] off;
  logic [7:0] up;
  logic [7:0] dn;

  always_comb begin
    off   = hue_i;
    rgb_o = '0;
    if (hue_i >= 8'd170)     off = hue_i - 8'd170;
    else if (hue_i >= 8'd85) off = hue_i - 8'd85;
    // off <= 85, so 3*off still fits in 8 bits
    up = {off[6:0], 1'b0} + off;
    dn = 8'd255 - up;
    if (hue_i < 8'd85)       rgb_o = {dn, up, 8'h00};
    else if (hue_i < 8'd170) rgb_o = {8'h00, dn, up};
    else                     rgb_o = {up, 8'h00, dn};
  end

endmodule

// File: rtl/led_strip_ctrl.sv
// LED-strip controller: accepts 4-bit op-codes over valid/ready, keeps
// power/mode/colour/brightness state and renders NUM_LEDS x 24-bit frames
// animated by a tick prescaler.
// Ports: clk_i, rst_n_i (async, active low); cmd_valid_i/cmd_ready_o/op_code_i
// command handshake; strip_o (LED i at [24*i+:24]); mode_o, color_code_o,
// brightness_o, powered_o state; frame_tick_o one-cycle pulse per tick.
// Build option: STRIP_FADE_EN -- brightness_o glides one level per FADE_DIV
// ticks toward a target set by the brightness commands.
//
// mode    | meaning
// SOLID   | every LED shows the palette colour
// BLINK   | palette colour on odd phase, dark on even phase
// RAINBOW | LED i shows hue phase*8 + i*HUE_STEP
// CHASE   | only LED (phase mod NUM_LEDS) lit with the palette colour
module led_strip_ctrl
  import led_strip_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int BRIGHT_W = 3,
  parameter int TICK_DIV = 4,
  parameter int HUE_STEP = 25
`ifdef STRIP_FADE_EN
  ,
  parameter int FADE_DIV = 2
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [3:0]               op_code_i,
  output logic [NUM_LEDS*24-1:0]   strip_o,
  output logic [1:0]               mode_o,
  output logic [2:0]               color_code_o,
  output logic [BRIGHT_W-1:0]      brightness_o,
  output logic                     powered_o,
  output logic                     frame_tick_o
);

  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = '1;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic                   cmd_ready_q;
  logic                   powered_q, powered_d;
  mode_e                  mode_q, mode_d;
  logic [2:0]             color_q, color_d;
  logic [2:0]             prev_q, prev_d;
  logic [BRIGHT_W-1:0]    bright_q, bright_d;
  logic [BRIGHT_W-1:0]    lvl_cur, lvl_nxt;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [7:0]             phase_q, phase_d;
  logic                   frame_tick_q;
  logic [NUM_LEDS*24-1:0] strip_q, strip_d;
  logic                   accept, tick, mode_chg;

  assign accept = cmd_valid_i && cmd_ready_q;
  assign tick   = (presc_q == PRESC_W'(TICK_DIV - 1));

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [BRIGHT_W-1:0] b);
    logic [8+BRIGHT_W:0] p;
    p = {{(BRIGHT_W+1){1'b0}}, c} * {8'h00, {1'b0, b} + {{BRIGHT_W{1'b0}}, 1'b1}};
    return 8'(p >> BRIGHT_W);
  endfunction

  // Brightness commands act on the target level when fading, else directly.
`ifdef STRIP_FADE_EN
  localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  logic [BRIGHT_W-1:0] bright_tgt_q;
  logic [FADE_W-1:0]   fade_cnt_q, fade_cnt_d;
  assign lvl_cur = bright_tgt_q;

  always_comb begin
    bright_d   = bright_q;
    fade_cnt_d = fade_cnt_q;
    if (tick) begin
      if (fade_cnt_q == FADE_W'(FADE_DIV - 1)) begin
        fade_cnt_d = '0;
        if (bright_q < bright_tgt_q)      bright_d = bright_q + 1'b1;
        else if (bright_q > bright_tgt_q) bright_d = bright_q - 1'b1;
      end else begin
        fade_cnt_d = fade_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bright_tgt_q <= BRIGHT_MAX;
      fade_cnt_q   <= '0;
    end else begin
      bright_tgt_q <= lvl_nxt;
      fade_cnt_q   <= fade_cnt_d;
    end
  end
`else
  assign lvl_cur  = bright_q;
  assign bright_d = lvl_nxt;
`endif

  always_comb begin
    powered_d = powered_q;
    mode_d    = mode_q;
    color_d   = color_q;
    prev_d    = prev_q;
    lvl_nxt   = lvl_cur;
    mode_chg  = 1'b0;
    if (accept) begin
      if (op_code_i == OP_POWER_ON) begin
        powered_d = 1'b1;
        mode_d    = MODE_SOLID;
        color_d   = 3'd0;
        prev_d    = 3'd0;
        lvl_nxt   = BRIGHT_MAX;
      end else if (powered_q) begin
        if (op_code_i[3]) begin
          if (op_code_i[2:0] != color_q) begin
            prev_d  = color_q;
            color_d = op_code_i[2:0];
          end
        end else begin
          case (op_code_i)
            OP_NOP: ;
            OP_MODE_NEXT: begin
              mode_d   = mode_e'(mode_q + 2'd1);
              mode_chg = 1'b1;
            end
            OP_MODE_PREV: begin
              mode_d   = mode_e'(mode_q - 2'd1);
              mode_chg = 1'b1;
            end
            OP_COLOR_NEXT: begin
              prev_d  = color_q;
              color_d = color_q + 3'd1;
            end
            OP_COLOR_UNDO:  color_d = prev_q;
            OP_BRIGHT_UP:   if (lvl_cur != BRIGHT_MAX) lvl_nxt = lvl_cur + 1'b1;
            OP_BRIGHT_DOWN: if (lvl_cur != '0) lvl_nxt = lvl_cur - 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // A mode change restarts the animation; a tick landing on that edge is lost.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    phase_d = phase_q;
    if (mode_chg)  phase_d = '0;
    else if (tick) phase_d = phase_q + 8'd1;
  end

  logic [8:0] chase_idx;
  assign chase_idx = {1'b0, phase_q} % 9'(NUM_LEDS);

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
    logic [7:0] hue;
    rgb_t       hue_rgb;
    rgb_t       raw;

    assign hue = {phase_q[4:0], 3'b000} + 8'(g * HUE_STEP);

    led_hue_wheel u_hue (
      .hue_i (hue),
      .rgb_o (hue_rgb)
    );

    always_comb begin
      raw = '0;
      case (mode_q)
        MODE_SOLID:   raw = SOLID_PALETTE[color_q];
        MODE_BLINK:   raw = phase_q[0] ? SOLID_PALETTE[color_q] : '0;
        MODE_RAINBOW: raw = hue_rgb;
        MODE_CHASE:   raw = (chase_idx == 9'(g)) ? SOLID_PALETTE[color_q] : '0;
        default:      raw = '0;
      endcase
    end

    assign strip_d[24*g +: 24] = powered_q ?
        {scale(raw[23:16], bright_q), scale(raw[15:8], bright_q), scale(raw[7:0], bright_q)} : 24'h0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_ready_q  <= 1'b1;
      powered_q    <= 1'b0;
      mode_q       <= MODE_SOLID;
      color_q      <= 3'd0;
      prev_q       <= 3'd0;
      bright_q     <= BRIGHT_MAX;
      presc_q      <= '0;
      phase_q      <= '0;
      frame_tick_q <= 1'b0;
      strip_q      <= '0;
    end else begin
      cmd_ready_q  <= !accept;
      powered_q    <= powered_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
      prev_q       <= prev_d;
      bright_q     <= bright_d;
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      frame_tick_q <= tick && !mode_chg;
      strip_q      <= strip_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign strip_o      = strip_q;
  assign mode_o       = mode_q;
  assign color_code_o = color_q;
  assign brightness_o = bright_q;
  assign powered_o    = powered_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_led_strip_ctrl.sv
// Directed bench for led_strip_ctrl (NUM_LEDS=10, BRIGHT_W=3, TICK_DIV=4).
module tb_led_strip_ctrl;

  localparam int N = 10;

  logic          clk, rst_n, cmd_valid, cmd_ready, powered, frame_tick;
  logic [3:0]    op_code;
  logic [N*24-1:0] strip;
  logic [1:0]    mode;
  logic [2:0]    color_code, brightness;

  int total  = 0;
  int passed = 0;

  led_strip_ctrl #(.NUM_LEDS(N), .BRIGHT_W(3), .TICK_DIV(4), .HUE_STEP(25)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .op_code_i    (op_code),
    .strip_o      (strip),
    .mode_o       (mode),
    .color_code_o (color_code),
    .brightness_o (brightness),
    .powered_o    (powered),
    .frame_tick_o (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  color;
    logic [1:0]  mode;
    logic [2:0]  bright;
    logic        pwr;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op);
    int n = 0;
    while (!cmd_ready && n < 8) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", {255'd0, cmd_ready}, 256'd1);
    cmd_valid = 1'b1;
    op_code   = op;
    step();
    cmd_valid = 1'b0;
    op_code   = 4'd0;
  endtask

  function automatic logic [N*24-1:0] exp_strip(input vec_t v);
    logic [N*24-1:0] s = '0;
    if (v.pwr) begin
      for (int i = 0; i < N; i++) begin
        if (v.mode == 2'd0 || (v.mode == 2'd3 && i == 0)) s[24*i +: 24] = v.rgb;
      end
    end
    return s;
  endfunction

  function automatic int lit(input logic [N*24-1:0] s);
    int n = 0;
    int k = -1;
    for (int i = 0; i < N; i++) begin
      if (s[24*i +: 24] != 24'h0) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  initial begin
    int last, idx, changes, gap, ticks, n;
    vec_t v;

    rst_n = 1'b0; cmd_valid = 1'b0; op_code = 4'd0;
    // unpowered: ignored
    tbl.push_back('{4'd6,  3'd0, 2'd0, 3'd7, 1'b0, 24'h000000});
    tbl.push_back('{4'd2,  3'd0, 2'd0, 3'd7, 1'b0, 24'h000000});
    tbl.push_back('{4'd10, 3'd0, 2'd0, 3'd7, 1'b0, 24'h000000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd7, 1'b0, 24'h000000});
    tbl.push_back('{4'd1,  3'd0, 2'd0, 3'd7, 1'b1, 24'hFF0000});
    tbl.push_back('{4'd10, 3'd2, 2'd0, 3'd7, 1'b1, 24'h0000FF});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd7, 1'b1, 24'h0000FF});
    tbl.push_back('{4'd8,  3'd0, 2'd0, 3'd7, 1'b1, 24'hFF0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd6, 1'b1, 24'hDF0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd5, 1'b1, 24'hBF0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd4, 1'b1, 24'h9F0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd3, 1'b1, 24'h7F0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd2, 1'b1, 24'h5F0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd1, 1'b1, 24'h3F0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd0, 1'b1, 24'h1F0000});
    tbl.push_back('{4'd7,  3'd0, 2'd0, 3'd0, 1'b1, 24'h1F0000});
    tbl.push_back('{4'd6,  3'd0, 2'd0, 3'd1, 1'b1, 24'h3F0000});
    tbl.push_back('{4'd5,  3'd2, 2'd0, 3'd1, 1'b1, 24'h00003F});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd2, 1'b1, 24'h00005F});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd3, 1'b1, 24'h00007F});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd4, 1'b1, 24'h00009F});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd5, 1'b1, 24'h0000BF});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd6, 1'b1, 24'h0000DF});
    tbl.push_back('{4'd6,  3'd2, 2'd0, 3'd7, 1'b1, 24'h0000FF});
    tbl.push_back('{4'd15, 3'd7, 2'd0, 3'd7, 1'b1, 24'hFFFFFF});
    tbl.push_back('{4'd4,  3'd0, 2'd0, 3'd7, 1'b1, 24'hFF0000});
    tbl.push_back('{4'd5,  3'd7, 2'd0, 3'd7, 1'b1, 24'hFFFFFF});
    tbl.push_back('{4'd15, 3'd7, 2'd0, 3'd7, 1'b1, 24'hFFFFFF});
    tbl.push_back('{4'd5,  3'd7, 2'd0, 3'd7, 1'b1, 24'hFFFFFF});
    tbl.push_back('{4'd12, 3'd4, 2'd0, 3'd7, 1'b1, 24'hFF6400});
    tbl.push_back('{4'd13, 3'd5, 2'd0, 3'd7, 1'b1, 24'hFF00FF});
    tbl.push_back('{4'd5,  3'd4, 2'd0, 3'd7, 1'b1, 24'hFF6400});
    tbl.push_back('{4'd7,  3'd4, 2'd0, 3'd6, 1'b1, 24'hDF5700});
    tbl.push_back('{4'd6,  3'd4, 2'd0, 3'd7, 1'b1, 24'hFF6400});
    tbl.push_back('{4'd14, 3'd6, 2'd0, 3'd7, 1'b1, 24'h6400FF});
    tbl.push_back('{4'd11, 3'd3, 2'd0, 3'd7, 1'b1, 24'hFFFF00});
    tbl.push_back('{4'd9,  3'd1, 2'd0, 3'd7, 1'b1, 24'h00FF00});
    tbl.push_back('{4'd0,  3'd1, 2'd0, 3'd7, 1'b1, 24'h00FF00});
    tbl.push_back('{4'd3,  3'd1, 2'd3, 3'd7, 1'b1, 24'h00FF00});
    tbl.push_back('{4'd2,  3'd1, 2'd0, 3'd7, 1'b1, 24'h00FF00});
    tbl.push_back('{4'd2,  3'd1, 2'd1, 3'd7, 1'b1, 24'h00FF00});
    tbl.push_back('{4'd3,  3'd1, 2'd0, 3'd7, 1'b1, 24'h00FF00});

    repeat (3) step();
    chk("rst_powered",    {255'd0, powered},    256'd0);
    chk("rst_mode",       {254'd0, mode},       256'd0);
    chk("rst_color",      {253'd0, color_code}, 256'd0);
    chk("rst_bright",     {253'd0, brightness}, 256'd7);
    chk("rst_strip",      {16'd0, strip},       256'd0);
    chk("rst_ready",      {255'd0, cmd_ready},  256'd1);
    chk("rst_frame_tick", {255'd0, frame_tick}, 256'd0);
    rst_n = 1'b1;

    send(4'd4);
    chk("unpow_accept_ready", {255'd0, cmd_ready}, 256'd0);
    step();
    chk("unpow_color",   {253'd0, color_code}, 256'd0);
    chk("unpow_powered", {255'd0, powered},    256'd0);
    chk("unpow_strip",   {16'd0, strip},       256'd0);

    foreach (tbl[r]) begin
      v = tbl[r];
      send(v.op);
      step();
      chk($sformatf("row%0d_state", r), {245'd0, color_code, mode, brightness, powered},
          {245'd0, v.color, v.mode, v.bright, v.pwr});
      chk($sformatf("row%0d_strip", r), {16'd0, strip}, {16'd0, exp_strip(v)});
    end

    // rainbow at phase 0: LED i hue = 25*i
    send(4'd2);
    send(4'd2);
    step();
    chk("rainbow_mode", {254'd0, mode}, 256'd2);
    chk("rainbow_led0", {232'd0, strip[0 +: 24]},   256'hFF0000);
    chk("rainbow_led1", {232'd0, strip[24 +: 24]},  256'hB44B00);
    chk("rainbow_led4", {232'd0, strip[96 +: 24]},  256'h00D22D);
    chk("rainbow_led7", {232'd0, strip[168 +: 24]}, 256'h0F00F0);

    // chase: one step per 4 clocks, 9 -> 0 wrap
    send(4'd2);
    step();
    chk("chase_mode", {254'd0, mode}, 256'd3);
    last = lit(strip);
    chk("chase_start", 256'(last), 256'd0);
    changes = 0;
    gap = 0;
    for (int c = 0; c < 80 && changes < 11; c++) begin
      step();
      gap++;
      idx = lit(strip);
      if (idx != last) begin
        changes++;
        chk("chase_next", 256'(idx), 256'((last + 1) % N));
        if (changes > 1) chk("chase_period", 256'(gap), 256'd4);
        gap = 0;
        last = idx;
      end
    end
    chk("chase_changes", 256'(changes), 256'd11);

    ticks = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (frame_tick) ticks++;
    end
    chk("frame_tick_count", 256'(ticks), 256'd10);

    // back-to-back valid: second cycle must not be accepted
    n = 0;
    while (!cmd_ready && n < 8) begin step(); n++; end
    cmd_valid = 1'b1;
    op_code   = 4'd4;
    step();
    chk("b2b_ready_low", {255'd0, cmd_ready},  256'd0);
    chk("b2b_color1",    {253'd0, color_code}, 256'd2);
    step();
    chk("b2b_color2",    {253'd0, color_code}, 256'd2);
    chk("b2b_ready_back", {255'd0, cmd_ready}, 256'd1);
    cmd_valid = 1'b0;
    op_code   = 4'd0;

    // blink then asynchronous reset
    send(4'd3);
    send(4'd3);
    step();
    chk("blink_mode", {254'd0, mode}, 256'd1);
    n = 0;
    while (strip == '0 && n < 20) begin step(); n++; end
    chk("blink_lit", {16'd0, strip}, {16'd0, {N{24'h0000FF}}});
    #2 rst_n = 1'b0;
    #1;
    chk("async_strip",   {16'd0, strip},       256'd0);
    chk("async_mode",    {254'd0, mode},       256'd0);
    chk("async_powered", {255'd0, powered},    256'd0);
    chk("async_color",   {253'd0, color_code}, 256'd0);
    chk("async_ready",   {255'd0, cmd_ready},  256'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_bright", {253'd0, brightness}, 256'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
